gravity_tick_gen: RTL and testbench

//  Parametrised successor to the single-rate auto-down ticker of the falling-block game.

---
 rtl/gravity_tick_gen.sv | 95 +++++++++
 tb/tb_gravity_tick_gen.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/gravity_tick_gen.sv
// gravity_tick_gen: level-scaled gravity, soft-drop, hard-drop and pause move-down strobe generator
module gravity_tick_gen #(
  parameter int CNT_W       = 25,
  parameter int LEVEL_W     = 4,
  parameter int BASE_PERIOD = 20_000_000,
  parameter int LEVEL_STEP  = 1_250_000,
  parameter int MIN_PERIOD  = 2_000_000,
  parameter int SOFT_PERIOD = 3_000_000,
  parameter int HARD_GAP    = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  input  logic [LEVEL_W-1:0] level,
  input  logic               down,
  input  logic               hard_drop,
  input  logic               landed,
  input  logic               restart,
  output logic               move_pulse,
  output logic [1:0]         mode
);
  localparam int PW = CNT_W + LEVEL_W + 1;
  localparam logic signed [PW-1:0] BASE_S = PW'(BASE_PERIOD);
  localparam logic signed [PW-1:0] STEP_S = PW'(LEVEL_STEP);
  localparam logic signed [PW-1:0] MIN_S = PW'(MIN_PERIOD);
  localparam logic [CNT_W-1:0] RST_PERIOD = CNT_W'(BASE_PERIOD > MIN_PERIOD ? BASE_PERIOD : MIN_PERIOD);
  localparam logic [CNT_W-1:0] SOFT_LAST = CNT_W'(SOFT_PERIOD - 1);
  localparam logic [CNT_W-1:0] HARD_LAST = CNT_W'(HARD_GAP - 1);
  typedef enum logic [1:0] {PAUSE = 2'd0, RUN = 2'd1, SOFT = 2'd2, HARD = 2'd3} state_t;
  state_t state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d, period_q, period_d, p_cur, last;
  logic pulse_d, down_q, hard_q, down_rise, hard_rise, tick;
  logic signed [PW-1:0] lvl_s, p_raw;
  assign lvl_s = PW'(level);
  assign p_raw = BASE_S - lvl_s * STEP_S;
  assign p_cur = (p_raw < MIN_S) ? CNT_W'(MIN_PERIOD) : p_raw[CNT_W-1:0];
  assign down_rise = down & ~down_q;
  assign hard_rise = hard_drop & ~hard_q;
  assign last = (state == RUN) ? period_q - CNT_W'(1) : (state == SOFT) ? SOFT_LAST : HARD_LAST;
  assign tick = cnt >= last;
  assign mode = state;
  // next state, counter, latched period and pulse, in priority order
  always_comb begin
    state_d = state;
    cnt_d = cnt;
    period_d = period_q;
    pulse_d = 1'b0;
    if (restart) begin
      state_d = RUN;
      cnt_d = '0;
      period_d = p_cur;
    end else if (!enable) begin
      state_d = PAUSE;
    end else if (state == PAUSE) begin
      state_d = RUN;
      period_d = p_cur;
    end else if (state != HARD && hard_rise) begin
      state_d = HARD;
      cnt_d = '0;
      pulse_d = 1'b1;
    end else if (state == RUN && down_rise) begin
      state_d = SOFT;
      cnt_d = '0;
      pulse_d = 1'b1;
    end else if ((state == SOFT && !down) || (state == HARD && landed)) begin
      state_d = RUN;
      cnt_d = '0;
      period_d = p_cur;
    end else if (tick) begin
      cnt_d = '0;
      pulse_d = 1'b1;
      if (state == RUN) period_d = p_cur;
    end else begin
      cnt_d = cnt + CNT_W'(1);
    end
  end
  // state, counter, pulse and key-edge registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= RUN;
      cnt <= '0;
      period_q <= RST_PERIOD;
      move_pulse <= 1'b0;
      down_q <= 1'b0;
      hard_q <= 1'b0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      period_q <= period_d;
      move_pulse <= pulse_d;
      down_q <= down;
      hard_q <= hard_drop;
    end
  end
endmodule

// File: tb/tb_gravity_tick_gen.sv
// tb_gravity_tick_gen: directed and random checks of gravity_tick_gen against a deadline-style model
module tb_gravity_tick_gen;
  localparam int SOFT = 5;
  localparam int GAP = 1;
  logic clk = 1'b0;
  logic reset_n, enable, down, hard_drop, landed, restart, move_pulse;
  logic [3:0] level;
  logic [1:0] mode;
  int n_tests = 0;
  int n_fail = 0;
  int t = 0;
  int n, m;
  int m_mode, m_start, m_per, m_c;
  bit m_pulse, m_pd, m_ph;

  gravity_tick_gen #(
    .CNT_W(8), .LEVEL_W(4), .BASE_PERIOD(20), .LEVEL_STEP(4),
    .MIN_PERIOD(6), .SOFT_PERIOD(SOFT), .HARD_GAP(GAP)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .level(level), .down(down),
    .hard_drop(hard_drop), .landed(landed), .restart(restart),
    .move_pulse(move_pulse), .mode(mode)
  );

  always #5 clk = ~clk;

  function automatic int per_of(input int lv);
    int p;
    p = 20 - lv * 4;
    return p < 6 ? 6 : p;
  endfunction

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s t=%0d observed %0d expected %0d", tag, t, got, exp);
    end
  endtask

  // model: each phase has a start edge and a length; a pulse is due once the length has elapsed
  task automatic model_edge();
    bit dr, hr;
    dr = down && !m_pd;
    hr = hard_drop && !m_ph;
    m_pulse = 1'b0;
    if (!reset_n) begin
      m_mode = 1; m_start = t; m_per = 20; m_pd = 1'b0; m_ph = 1'b0;
    end else begin
      if (restart) begin
        m_mode = 1; m_start = t; m_per = per_of(level);
      end else if (!enable) begin
        if (m_mode != 0) begin m_c = t - m_start - 1; m_mode = 0; end
      end else if (m_mode == 0) begin
        m_mode = 1; m_start = t - m_c; m_per = per_of(level);
      end else if (m_mode != 3 && hr) begin
        m_mode = 3; m_pulse = 1'b1; m_start = t; m_per = GAP;
      end else if (m_mode == 1 && dr) begin
        m_mode = 2; m_pulse = 1'b1; m_start = t; m_per = SOFT;
      end else if ((m_mode == 2 && !down) || (m_mode == 3 && landed)) begin
        m_mode = 1; m_start = t; m_per = per_of(level);
      end else if (t - m_start >= m_per) begin
        m_pulse = 1'b1; m_start = t;
        m_per = m_mode == 1 ? per_of(level) : m_mode == 2 ? SOFT : GAP;
      end
      m_pd = down;
      m_ph = hard_drop;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("pulse", move_pulse, 8'(m_pulse));
    check("mode", mode, 8'(m_mode));
    t++;
  endtask

  task automatic gap(output int k);
    k = 0;
    do begin step(); k++; end while (!move_pulse && k < 100);
  endtask

  initial begin
    reset_n = 1'b1; enable = 1'b1; level = 4'd0; down = 1'b0;
    hard_drop = 1'b0; landed = 1'b0; restart = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check("rst_pulse", move_pulse, 0);
    check("rst_mode", mode, 1);
    step(); step();
    reset_n = 1'b1;
    gap(n); check("first_gap", n, 20);
    repeat (4) begin gap(n); check("gap_l0", n, 20); end
    n = 0;
    repeat (8) begin step(); n++; end
    level = 4'd2;
    gap(m); check("gap_lvl_mid", n + m, 20);
    gap(n); check("gap_l2", n, 12);
    level = 4'd5;
    gap(n); check("gap_l5_pending", n, 12);
    gap(n); check("gap_l5_min", n, 6);
    level = 4'd0;
    gap(n); check("gap_l0_pending", n, 6);
    gap(n); check("gap_l0_back", n, 20);
    down = 1'b1;
    step(); check("soft_entry_pulse", move_pulse, 1); check("soft_mode", mode, 2);
    repeat (5) begin gap(n); check("soft_gap", n, 5); end
    repeat (4) step();
    down = 1'b0;
    step(); check("soft_rel_mode", mode, 1); check("soft_rel_pulse", move_pulse, 0);
    gap(n); check("soft_rel_gap", n, 20);
    hard_drop = 1'b1; n = 0;
    repeat (7) begin step(); n += int'(move_pulse); end
    check("hard_pulses", n, 7); check("hard_mode", mode, 3);
    landed = 1'b1;
    step(); check("land_no_pulse", move_pulse, 0); check("land_mode", mode, 1);
    landed = 1'b0; hard_drop = 1'b0;
    gap(n); check("land_gap", n, 20);
    repeat (13) step();
    enable = 1'b0; n = 0;
    for (int i = 0; i < 50; i++) begin
      if (i == 20) down = 1'b1;
      step();
      n += int'(move_pulse);
    end
    check("pause_pulses", n, 0); check("pause_mode", mode, 0);
    enable = 1'b1;
    step(); check("resume_mode", mode, 1);
    gap(n); check("resume_gap", n, 7); check("held_key_no_soft", mode, 1);
    down = 1'b0;
    hard_drop = 1'b1;
    step(); step(); step(); check("hard_before_rst", mode, 3);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_pulse", move_pulse, 0); check("async_rst_mode", mode, 1);
    hard_drop = 1'b0;
    step();
    reset_n = 1'b1;
    repeat (7) step();
    restart = 1'b1;
    step(); check("restart_pulse", move_pulse, 0); check("restart_mode", mode, 1);
    restart = 1'b0;
    gap(n); check("restart_gap", n, 20);
    for (int i = 0; i < 3000; i++) begin
      enable = ($urandom_range(0, 99) < 96);
      if ($urandom_range(0, 19) == 0) level = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) down = ~down;
      if ($urandom_range(0, 14) == 0) hard_drop = ~hard_drop;
      landed = ($urandom_range(0, 9) == 0);
      restart = ($urandom_range(0, 199) == 0);
      step();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
